mips_avalon_bus_master: RTL and testbench

MIPS_AVALON_BUS_MASTER -- requirements
Module: mips_avalon_bus_master

---
 rtl/mips_avalon_bus_master.sv | 112 +++++++++++
 tb/tb_mips_avalon_bus_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_bus_master.sv
// mips_avalon_bus_master: bridges single-outstanding MIPS load/store requests onto an Avalon-MM master port.
// Define MIPS_AVALON_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES waitrequest cycles.
module mips_avalon_bus_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [1:0] lane, size;
  logic bad;
  logic [3:0] be_c;
  logic [31:0] wd_c, shifted, rd_c;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end
`ifdef MIPS_AVALON_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`endif
  assign req_ready = state == IDLE;
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    be_c = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] : req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_c = req_size == 2'b00 ? {4{req_wdata[7:0]}} : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    shifted = readdata >> {lane, 3'b000};
    rd_c = size == 2'b00 ? {24'h0, shifted[7:0]} : size == 2'b01 ? {16'h0, shifted[15:0]} : shifted;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      read <= 1'b0;
      write <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      address <= '0;
      writedata <= '0;
      byteenable <= '0;
      lane <= '0;
      size <= '0;
`ifdef MIPS_AVALON_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lane <= req_addr[1:0];
          size <= req_size;
          if (bad) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state <= BUSY;
            address <= {req_addr[31:2], 2'b00};
            read <= !req_write;
            write <= req_write;
            writedata <= wd_c;
            byteenable <= be_c;
`ifdef MIPS_AVALON_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        BUSY: if (!waitrequest) begin
          state <= RESP;
          read <= 1'b0;
          write <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= read ? rd_c : '0;
        end
`ifdef MIPS_AVALON_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state <= RESP;
          read <= 1'b0;
          write <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          resp_rdata <= '0;
        end else cnt <= cnt + 1'b1;
`endif
        RESP: begin
          state <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_avalon_bus_master.sv
// tb_mips_avalon_bus_master: randomized scoreboard bench with a byte-lane reference model.
module tb_mips_avalon_bus_master;
  localparam int TMO = 4;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_write = 0, waitrequest = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, readdata = 0;
  logic req_ready, resp_valid, resp_error, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0] byteenable;
  int checks = 0, errors = 0, stall_left = 0, strobe_cycles = 0;

  typedef struct {logic w; logic [31:0] addr; logic [31:0] wd; logic [3:0] be;} bus_t;
  typedef struct {logic [31:0] rd; logic err;} resp_t;
  bus_t exp_bus[$];
  resp_t exp_resp[$];

  mips_avalon_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lanes occupied by the access, data replicated per lane, load bytes gathered from those lanes.
  function automatic bit model(input logic w, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input bit tmo);
    int n, off;
    bus_t b;
    resp_t r;
    bit bad;
    off = int'(a & 32'd3);
    n = 1 << sz;
    bad = sz == 2'b11 || off % n != 0;
    if (!bad) begin
      b.w = w;
      b.addr = a & 32'hFFFF_FFFC;
      b.be = 4'b0000;
      b.wd = 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + n) b.be[i] = 1'b1;
        b.wd[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      exp_bus.push_back(b);
    end
    r.err = bad || tmo;
    r.rd = 32'h0;
    if (!r.err && !w)
      for (int i = 0; i < n; i++) r.rd[8*i +: 8] = rd[8*(off + i) +: 8];
    exp_resp.push_back(r);
    return bad;
  endfunction

  always @(negedge clk) if ((read || write) && stall_left > 0) stall_left--;
  always @(posedge clk) begin
    #1;
    waitrequest = stall_left != 0;
  end
  always @(negedge clk) if (read || write) strobe_cycles++;

  always @(negedge clk) begin
    bus_t b;
    if (!reset && (read || write)) begin
      if (exp_bus.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got read=%b write=%b expected no strobe at %0t", read, write, $time);
      end else begin
        b = exp_bus[0];
        check("bus_write", 32'(write), 32'(b.w));
        check("bus_read", 32'(read), 32'(!b.w));
        check("bus_address", address, b.addr);
        check("bus_byteenable", 32'(byteenable), 32'(b.be));
        if (b.w) check("bus_writedata", writedata, b.wd);
        if (!waitrequest) void'(exp_bus.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    resp_t r;
    if (!reset && resp_valid) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata=%h error=%b expected none at %0t", resp_rdata, resp_error, $time);
      end else begin
        r = exp_resp.pop_front();
        check("resp_rdata", resp_rdata, r.rd);
        check("resp_error", 32'(resp_error), 32'(r.err));
        check("ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
  end

  task automatic reset_checks();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_byteenable", 32'(byteenable), 32'd0);
  endtask

  // Called just after a rising edge with the block idle.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int wn, input bit tmo);
    bit bad;
    int turn;
    bad = model(w, sz, a, wd, rd, tmo);
    readdata = rd;
    stall_left = tmo ? 100000 : wn;
    waitrequest = stall_left != 0;
    strobe_cycles = 0;
    req_write = w;
    req_size = sz;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_write = $urandom_range(0, 1);
    req_addr = $urandom;
    req_wdata = $urandom;
    turn = 0;
    while (!req_ready && turn < 2000) begin
      @(posedge clk);
      #1;
      turn++;
    end
    check("turnaround", turn, bad ? 1 : tmo ? TMO + 1 : wn + 2);
    check("strobe_cycles", strobe_cycles, bad ? 0 : tmo ? TMO : wn + 1);
    if (tmo && exp_bus.size() > 0) void'(exp_bus.pop_front());
    check("resp_pending", exp_resp.size(), 0);
    stall_left = 0;
    waitrequest = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    reset = 0;
    @(posedge clk);
    #1;
    do_req(0, 2'b10, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 2, 0);
    do_req(1, 2'b00, 32'h0000_0007, 32'h0000_00A5, 32'h0, 1, 0);
    do_req(0, 2'b01, 32'hBFC0_0002, 32'h0, 32'h1234_ABCD, 0, 0);
    do_req(0, 2'b10, 32'h0000_0006, 32'h0, 32'h1111_1111, 0, 0);
    do_req(1, 2'b01, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0, 0, 0);
    do_req(0, 2'b11, 32'h0000_0008, 32'h0, 32'h2222_2222, 0, 0);
    do_req(0, 2'b00, 32'h0000_0001, 32'h0, 32'h8899_AABB, 0, 0);
    do_req(1, 2'b10, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 0, 0);
    // Abandon a stalled store with an asynchronous reset.
    void'(model(1, 2'b10, 32'h0000_0100, 32'h1357_9BDF, 32'h0, 0));
    stall_left = 100000;
    waitrequest = 1;
    req_write = 1;
    req_size = 2'b10;
    req_addr = 32'h0000_0100;
    req_wdata = 32'h1357_9BDF;
    req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    #2;
    check("busy_write_before_reset", 32'(write), 32'd1);
    reset = 1;
    #1;
    reset_checks();
    exp_bus.delete();
    exp_resp.delete();
    stall_left = 0;
    waitrequest = 0;
    @(posedge clk);
    #1;
    reset = 0;
    do_req(0, 2'b10, 32'h0000_0004, 32'h0, 32'h0BAD_CAFE, 0, 0);
`ifdef MIPS_AVALON_TIMEOUT_EN
    do_req(0, 2'b10, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 0, 1);
    do_req(1, 2'b00, 32'h0000_0041, 32'h0000_0077, 32'h0, 0, 1);
`endif
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom_range(0, 3), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("bus_queue_empty", exp_bus.size(), 0);
    check("resp_queue_empty", exp_resp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
